// File: rtl/fetch_unit.sv
// fetch_unit: RV32I IF stage - PC generation, imem req/ack, instruction FIFO.
// Optional macro FETCH_MISALIGN_TRAP_EN: o_misaligned, fetch frozen on misaligned redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic [31:0] i_branch_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        o_misaligned,
`endif
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_ce
);

    localparam int AW = (FIFO_DEPTH == 4) ? 2 : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [31:0]    r_addr;
    logic [31:0]    r_fifo_pc    [FIFO_DEPTH];
    logic [31:0]    r_fifo_instr [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  w_count_nxt;
    logic           w_push;
    logic           w_pop;
    logic           w_bad;
    logic           w_frozen;
    logic [31:0]    w_target;
    logic [31:0]    r_instr;
    logic [31:0]    r_pc;
    logic           r_ce;

    assign w_target = i_branch_pc & 32'hFFFF_FFFC;
    assign w_push   = (r_state == S_REQ) && i_imem_ack && !i_flush;
    assign w_pop    = !i_flush && !i_stall && (r_count != '0);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_mis;
    assign w_bad        = i_flush && (i_branch_pc[1:0] != 2'b00);
    assign w_frozen     = r_mis;
    assign o_misaligned = r_mis;

    // Misaligned-redirect flag: set by a misaligned flush, cleared by an aligned one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_mis <= 1'b0;
        else if (i_flush) r_mis <= w_bad;
    end
`else
    assign w_bad    = 1'b0;
    assign w_frozen = 1'b0;
`endif

    assign o_imem_req  = (r_state == S_REQ);
    assign o_imem_addr = r_addr;
    assign o_instr     = r_instr;
    assign o_pc        = r_pc;
    assign o_ce        = r_ce;

    // FIFO occupancy after this cycle's push/pop (flush empties it).
    always_comb begin
        w_count_nxt = r_count;
        if (i_flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Next-state: keep requesting while the buffer has room, redirect on flush.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  w_state_nxt = S_REQ;
            S_REQ:   if (w_count_nxt >= DEPTH_C) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_count_nxt < DEPTH_C && !w_frozen) w_state_nxt = S_REQ;
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_flush) w_state_nxt = w_bad ? S_DRAIN : S_REQ;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Fetch address: advances on each accepted word, jumps on redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_addr <= RESET_PC;
        else if (i_flush) r_addr <= w_target;
        else if (w_push)  r_addr <= r_addr + 32'd4;
    end

    // FIFO payload storage; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_addr;
            r_fifo_instr[r_wr_ptr] <= i_imem_rdata;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // IF/ID output register: pops the FIFO head unless stalled, NOP on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= NOP;
            r_pc    <= 32'h0;
            r_ce    <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP;
            r_ce    <= 1'b0;
            if (w_bad) r_pc <= i_branch_pc;
        end else if (!i_stall) begin
            r_ce <= w_pop;
            if (w_pop) begin
                r_instr <= r_fifo_instr[r_rd_ptr];
                r_pc    <= r_fifo_pc[r_rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit
// against a queue-based reference model of the fetch stream.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] PAT    = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        i_stall;
    logic        i_flush;
    logic [31:0] i_branch_pc;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_ce;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        o_misaligned;
    logic        exp_mis;
`endif

    logic [31:0] q_pc[$];
    logic [31:0] q_in[$];
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic        exp_ce;
    int          n_chk;
    int          n_fail;

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_ack   (i_imem_ack),
        .i_imem_rdata (i_imem_rdata),
        .i_stall      (i_stall),
        .i_flush      (i_flush),
        .i_branch_pc  (i_branch_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
        .o_misaligned (o_misaligned),
`endif
        .o_instr      (o_instr),
        .o_pc         (o_pc),
        .o_ce         (o_ce)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        q_pc.delete();
        q_in.delete();
        exp_addr  = RST_PC;
        exp_instr = NOP;
        exp_pc    = 32'h0;
        exp_ce    = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        exp_mis   = 1'b0;
`endif
    endtask

    // One clock: drive inputs, memory answers requests, model predicts, compare.
    task automatic cycle(input logic stall, input logic flush,
                         input logic [31:0] bpc, input logic ack_en,
                         input logic force_ack);
        logic req;
        req          = o_imem_req;
        i_stall      = stall;
        i_flush      = flush;
        i_branch_pc  = bpc;
        i_imem_ack   = force_ack | (req & ack_en);
        i_imem_rdata = o_imem_addr ^ PAT;
        if (req) begin
            n_chk++;
            if (o_imem_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL req_addr got=%h exp=%h", o_imem_addr, exp_addr);
            end
            n_chk++;
            if (q_pc.size() >= DEPTH) begin
                n_fail++;
                $display("FAIL req_when_full got=req exp=no_req (fill %0d)", q_pc.size());
            end
        end
        if (flush) begin
            q_pc.delete();
            q_in.delete();
            exp_ce    = 1'b0;
            exp_instr = NOP;
            exp_addr  = bpc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
            exp_mis = (bpc[1:0] != 2'b00);
            if (exp_mis) exp_pc = bpc;
`endif
        end else begin
            if (!stall) begin
                if (q_pc.size() > 0) begin
                    exp_pc    = q_pc.pop_front();
                    exp_instr = q_in.pop_front();
                    exp_ce    = 1'b1;
                end else begin
                    exp_ce = 1'b0;
                end
            end
            if (req && i_imem_ack) begin
                q_pc.push_back(exp_addr);
                q_in.push_back(exp_addr ^ PAT);
                exp_addr = exp_addr + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        i_imem_ack = 1'b0;
        n_chk++;
        if (o_ce !== exp_ce) begin
            n_fail++;
            $display("FAIL ce got=%0b exp=%0b", o_ce, exp_ce);
        end
        n_chk++;
        if (o_pc !== exp_pc) begin
            n_fail++;
            $display("FAIL pc got=%h exp=%h", o_pc, exp_pc);
        end
        n_chk++;
        if (o_instr !== exp_instr) begin
            n_fail++;
            $display("FAIL instr got=%h exp=%h", o_instr, exp_instr);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        n_chk++;
        if (o_misaligned !== exp_mis) begin
            n_fail++;
            $display("FAIL misaligned got=%0b exp=%0b", o_misaligned, exp_mis);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (o_imem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_req got=%0b exp=0", o_imem_req);
        end
        n_chk++;
        if (o_imem_addr !== RST_PC) begin
            n_fail++; $display("FAIL reset_addr got=%h exp=%h", o_imem_addr, RST_PC);
        end
        n_chk++;
        if (o_instr !== NOP) begin
            n_fail++; $display("FAIL reset_instr got=%h exp=%h", o_instr, NOP);
        end
        n_chk++;
        if (o_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_pc got=%h exp=0", o_pc);
        end
        n_chk++;
        if (o_ce !== 1'b0) begin
            n_fail++; $display("FAIL reset_ce got=%0b exp=0", o_ce);
        end
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        n_chk++;
        if (o_imem_req !== 1'b0) begin
            n_fail++; $display("FAIL idle_req got=%0b exp=0", o_imem_req);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        n_chk++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL first_req got=%0b/%h exp=1/%h", o_imem_req, o_imem_addr, RST_PC);
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_wait();
        for (int n = 0; n < 4; n++) begin
            repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        n_chk++;
        if (o_imem_req !== 1'b0) begin
            n_fail++; $display("FAIL stall_full_req got=%0b exp=0", o_imem_req);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        n_chk++;
        if (o_imem_req !== 1'b1) begin
            n_fail++; $display("FAIL req_after_pop got=%0b exp=1", o_imem_req);
        end
        repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        bit found;
        cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (o_imem_req === 1'b1 && exp_addr == 32'h10) found = 1'b1;
            else cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        n_chk++;
        if (!found) begin
            n_fail++; $display("FAIL reach_0x10 got=timeout exp=req_at_10");
        end
        cycle(1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
        n_chk++;
        if (o_ce !== 1'b0 || o_instr !== NOP) begin
            n_fail++; $display("FAIL flush_out got=%0b/%h exp=0/%h", o_ce, o_instr, NOP);
        end
        n_chk++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL flush_addr got=%0b/%h exp=1/00000100", o_imem_req, o_imem_addr);
        end
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            if (o_ce === 1'b1) found = 1'b1;
        end
        n_chk++;
        if (!found || o_pc !== 32'h100) begin
            n_fail++; $display("FAIL flush_first_pc got=%h exp=00000100", o_pc);
        end
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_flush_stall_reset();
        cycle(1'b1, 1'b1, 32'h40, 1'b0, 1'b0);
        n_chk++;
        if (o_ce !== 1'b0 || o_instr !== NOP) begin
            n_fail++; $display("FAIL flush_stall_out got=%0b/%h exp=0/%h", o_ce, o_instr, NOP);
        end
        n_chk++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL flush_stall_addr got=%0b/%h exp=1/00000040", o_imem_req, o_imem_addr);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        n_chk++;
        if (o_imem_req !== 1'b0 || o_ce !== 1'b0) begin
            n_fail++; $display("FAIL async_rst got=%0b/%0b exp=0/0", o_imem_req, o_ce);
        end
        n_chk++;
        if (o_imem_addr !== RST_PC || o_instr !== NOP) begin
            n_fail++; $display("FAIL async_rst_addr got=%h/%h exp=%h/%h",
                               o_imem_addr, o_instr, RST_PC, NOP);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_chk++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL restart got=%0b/%h exp=1/%h", o_imem_req, o_imem_addr, RST_PC);
        end
        repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        n_chk++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL wrap got=%0b/%h exp=1/00000000", o_imem_req, o_imem_addr);
        end
        repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

`ifdef FETCH_MISALIGN_TRAP_EN
    task automatic test_misalign();
        cycle(1'b0, 1'b1, 32'h102, 1'b1, 1'b0);
        n_chk++;
        if (o_misaligned !== 1'b1 || o_pc !== 32'h102 || o_ce !== 1'b0) begin
            n_fail++; $display("FAIL mis_set got=%0b/%h/%0b exp=1/00000102/0",
                               o_misaligned, o_pc, o_ce);
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (o_imem_req !== 1'b0) begin
                n_fail++; $display("FAIL mis_frozen got=%0b exp=0", o_imem_req);
            end
            cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        cycle(1'b0, 1'b1, 32'h200, 1'b1, 1'b0);
        n_chk++;
        if (o_misaligned !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h200) begin
            n_fail++; $display("FAIL mis_clear got=%0b/%0b/%h exp=0/1/00000200",
                               o_misaligned, o_imem_req, o_imem_addr);
        end
        repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask
`else
    task automatic test_unaligned();
        cycle(1'b0, 1'b1, 32'h102, 1'b1, 1'b0);
        n_chk++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL unaligned got=%0b/%h exp=1/00000100", o_imem_req, o_imem_addr);
        end
        repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask
`endif

    task automatic test_random();
        logic        st;
        logic        fl;
        logic        ak;
        logic [31:0] bp;
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 24) == 0);
            ak = $urandom_range(0, 1) == 1;
            bp = 32'($urandom_range(0, 1023)) << 2;
            cycle(st, fl, bp, ak, 1'b0);
        end
    endtask

    initial begin
        n_chk        = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        i_imem_ack   = 1'b0;
        i_imem_rdata = 32'h0;
        i_stall      = 1'b0;
        i_flush      = 1'b0;
        i_branch_pc  = 32'h0;
        model_reset();
        test_reset();
        test_basic();
        test_wait();
        test_stall();
        test_flush();
        test_flush_stall_reset();
        test_wrap();
`ifdef FETCH_MISALIGN_TRAP_EN
        test_misalign();
`else
        test_unaligned();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
